// File: rtl/float64_add_requester_pkg.sv
// Shared types and constants for the float64 add requester.
// States: IDLE (accepting), ISSUE (start pulse), WAIT (adder busy), HOLD (result buffered).
package float64_req_pkg;

    localparam int DEFAULT_DATA_W = 64;

    // Quiet NaN substituted for a result the adder never delivered.
    localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } req_state_e;

endpackage

// File: rtl/float64_add_requester_if.sv
// Start/fin handshake between the requester (master) and the float64 adder (slave).
// The operands must stay stable from the start cycle until fin.
interface float64_add_requester_if
    import float64_req_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              fin;
    logic [DATA_W-1:0] return_value;

    modport master (
        output start,
        output a,
        output b,
        input  fin,
        input  return_value
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output fin,
        output return_value
    );

endinterface

// File: rtl/float64_add_requester_timeout.sv
// WAIT-state watchdog for the float64 add requester.
// Cleared by load, counts while enabled, flags when it reaches LIMIT-1.
// Only instantiated when FLOAT64_REQ_TIMEOUT_EN is defined.
module req_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(LIMIT - 1));

    // Next count: clear on load, otherwise advance until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/float64_add_requester.sv
// Initiator side of the float64 adder start/fin handshake.
// Accepts operand pairs on a valid/ready port, issues one add at a time,
// buffers the result in a one-entry output stage and presents it downstream.
// Optional macro FLOAT64_REQ_TIMEOUT_EN adds a WAIT-state watchdog that
// substitutes a quiet NaN (out_err=1) when the adder never answers.
module float64_add_requester
    import float64_req_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstN,        // synchronous, active-high despite the name

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,

    float64_add_requester_if.master add_if,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_err,
    output logic [CNT_W-1:0]        done_cnt,
    output logic                    spurious_fin
);

    req_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              start_q, start_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic              spurious_q, spurious_d;

    // High in the WAIT cycle where the watchdog gives up on the adder.
    logic              timeout_hit;

`ifdef FLOAT64_REQ_TIMEOUT_EN
    logic timeout_load;
    logic timeout_enable;
    logic timeout_expired;

    // The counter clears during ISSUE so it reads zero on WAIT entry,
    // and advances on every WAIT cycle without fin.
    assign timeout_load   = (state_q == ISSUE);
    assign timeout_enable = (state_q == WAIT) && !add_if.fin;

    req_timeout_ctr #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rstN),
        .load    (timeout_load),
        .enable  (timeout_enable),
        .expired (timeout_expired)
    );

    assign timeout_hit = timeout_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // Adder-side outputs come straight from registers.
    assign add_if.start = start_q;
    assign add_if.a     = a_q;
    assign add_if.b     = b_q;

    // Downstream outputs come straight from registers.
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign done_cnt     = done_cnt_q;
    assign spurious_fin = spurious_q;

    // Next-state and handshake logic for the IDLE/ISSUE/WAIT/HOLD sequence.
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path leaves one unassigned (no latch).
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        start_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        done_cnt_d  = done_cnt_q;
        spurious_d  = spurious_q;
        in_ready    = 1'b0;

        // A fin outside WAIT belongs to no request: flag it and otherwise ignore it.
        if (add_if.fin && (state_q != WAIT)) begin
            spurious_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                // start_q is high for this single cycle; the default drops it.
                state_d = WAIT;
            end

            WAIT: begin
                // A fin in the limit cycle takes priority over the timeout.
                if (add_if.fin) begin
                    out_data_d  = add_if.return_value;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    done_cnt_d  = done_cnt_q + CNT_W'(1);
                    state_d     = HOLD;
                end else if (timeout_hit) begin
                    out_data_d  = DATA_W'(QNAN64);
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    state_d     = HOLD;
                end
            end

            HOLD: begin
                // in_ready stays low in the release cycle; IDLE accepts on the next one.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight add.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high; every register here is small control or data state, so all are cleared.
        if (rstN) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            done_cnt_q  <= '0;
            spurious_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            done_cnt_q  <= done_cnt_d;
            spurious_q  <= spurious_d;
        end
    end

endmodule

// File: doc/float64_add_requester.md
Name: float64_add_requester

Overview:
- Initiator side of the float64 adder start/fin handshake: the requester that drives the adder's operand/start inputs and collects its fin/return_value.
- Accepts operand pairs on a valid/ready upstream port and issues one add at a time to the adder.
- Captures each result into a one-entry output buffer and presents it on a valid/ready downstream port.
- Sits between a command source (sequencer or test harness) and the float64 add datapath.

Parameters:
- DATA_W, 64, operand/result width (IEEE-754 binary64).
- CNT_W, 32, width of the completed-transaction counter.
- TIMEOUT_CYCLES, 1024, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstN  in  1  synchronous reset, active-high (rstN=1 resets on the next clk edge); name kept per port convention.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  requester can accept a pair.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- start  out  1  to adder: one-cycle request pulse.
- a  out  DATA_W  to adder: operand a, stable from the start cycle until fin.
- b  out  DATA_W  to adder: operand b, stable from the start cycle until fin.
- fin  in  1  from adder: one-cycle completion pulse.
- return_value  in  DATA_W  from adder: result, valid in the fin cycle only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  captured result.
- out_err  out  1  result is a timeout substitute (tied 0 without the optional feature).
- done_cnt  out  CNT_W  completed transactions, wraps modulo 2^CNT_W.
- spurious_fin  out  1  sticky: fin observed outside WAIT.

Behaviour:
- Reset (rstN=1 at an edge): state=IDLE; start=0; a=b=0; out_valid=0; out_data=0; out_err=0; done_cnt=0; spurious_fin=0; timeout counter=0.
- Reset mid-operation: any in-flight add is abandoned; no result is produced. The adder must be reset in the same cycle.
- IDLE: in_ready=1. On in_valid&in_ready at edge t: a<=in_a, b<=in_b, start<=1 → ISSUE.
- ISSUE, one cycle: start=1 for exactly this cycle, then start<=0 → WAIT.
- WAIT: a and b held. When fin=1: out_data<=return_value, out_valid<=1, out_err<=0, done_cnt<=done_cnt+1 → HOLD.
- HOLD: out_valid=1, out_data stable. On out_valid&out_ready: out_valid<=0 → IDLE.
- No new pair is accepted in the release cycle; in_ready rises the following cycle.
- in_ready=0 in ISSUE, WAIT and HOLD.
- Latency: accept edge t → start high in cycle t+1 → out_valid high the cycle after fin.
- Minimum accept-to-accept period: adder latency + 3 cycles.
- The adder must not assert fin in the cycle start is high.
- fin in IDLE, ISSUE or HOLD: ignored for data and state; sets spurious_fin=1, which clears only on reset.
- done_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- Operands pass through unmodified; the block does no arithmetic on data.

Optional Feature:
- Macro: FLOAT64_REQ_TIMEOUT_EN.
- Defined:
  - The counter clears on WAIT entry and increments each WAIT cycle without fin.
  - If it reaches TIMEOUT_CYCLES−1 with fin still 0: out_data<=64'h7FF8_0000_0000_0000 (qNaN), out_err<=1, out_valid<=1 → HOLD. done_cnt is not incremented.
  - A late fin after timeout sets spurious_fin.
  - fin arriving in the limit cycle itself wins (normal result, out_err=0).
- Not defined: WAIT lasts indefinitely, out_err is tied 0, and no counter logic is generated.

Decomposition:
- Package float64_req_pkg: state enum (IDLE, ISSUE, WAIT, HOLD), localparam QNAN64=64'h7FF8_0000_0000_0000, DATA_W default.
- Optional sub-module req_timeout_ctr (load/enable/expired) instantiated only under the macro. Everything else lives in one module.

Test Plan:
- 1.0+2.0: in_a=3FF0000000000000, in_b=4000000000000000 → start pulses exactly 1 cycle; out_data=4008000000000000, out_err=0, done_cnt=1.
- Back-to-back pairs with in_valid held high and out_ready=1: (1.0,1.0) then (−2.5, 2.5) → outputs 4000000000000000 then 0000000000000000 in order; start never high while a result is pending.
- Backpressure: out_ready=0 for 20 cycles after result → out_valid and out_data stable, in_ready=0 throughout; release → IDLE next cycle.
- Reset asserted in WAIT → next cycle start=0, out_valid=0, in_ready=1; a later fin from the stale adder sets spurious_fin=1.
- Unsolicited fin in IDLE → spurious_fin=1, out_valid stays 0, done_cnt unchanged.
- With FLOAT64_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, adder never asserts fin → out_valid after 8 WAIT cycles, out_data=7FF8000000000000, out_err=1, done_cnt unchanged.
